// File: rtl/regfile_scoreboard_pkg.sv
// Shared configuration for the register file / scoreboard and its clients
// (issue unit, ROB): default widths, the hardwired-zero register and read-port source selection.
package regfile_scoreboard_pkg;

  localparam int unsigned RF_XLEN   = 32;
  localparam int unsigned RF_NREG   = 32;
  localparam int unsigned RF_TAG_W  = 4;
  localparam int unsigned RF_NUM_RD = 2;

  localparam int unsigned REG_ZERO = 0;
  localparam logic [RF_XLEN-1:0] ZERO_WORD = '0;

  // Where a read port takes its result from.
  typedef enum logic [1:0] {
    RD_SRC_OFF,
    RD_SRC_ZERO,
    RD_SRC_BYPASS,
    RD_SRC_ARRAY
  } rd_src_e;

endpackage

// File: rtl/regfile_scoreboard_rd_port.sv
// One combinational read port: enable/reset/flush gating, x0 handling,
// writeback bypass and the busy-clear visible through the bypass.
module regfile_rd_port
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned XLEN  = RF_XLEN,
  parameter int unsigned AW    = 5,
  parameter int unsigned TAG_W = RF_TAG_W
) (
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             en_i,
  input  logic [AW-1:0]    addr_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [XLEN-1:0]  wr_data_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [XLEN-1:0]  ent_data_i,
  input  logic             ent_busy_i,
  input  logic [TAG_W-1:0] ent_tag_i,
  output logic [XLEN-1:0]  data_o,
  output logic             busy_o,
  output logic [TAG_W-1:0] tag_o
);

  rd_src_e src;

  // Choose the result source in priority order.
  always_comb begin
    src = RD_SRC_ARRAY;
    if (rst_i || flush_i || !en_i) begin
      src = RD_SRC_OFF;
    end else if (addr_i == AW'(REG_ZERO)) begin
      src = RD_SRC_ZERO;
    end else if (wr_en_i && (wr_addr_i == addr_i)) begin
      src = RD_SRC_BYPASS;
    end
  end

  // Drive data/busy/tag from the selected source.
  always_comb begin
    data_o = XLEN'(ZERO_WORD);
    busy_o = 1'b0;
    tag_o  = '0;
    case (src)
      RD_SRC_BYPASS: begin
        data_o = wr_data_i;
        busy_o = ent_busy_i && (ent_tag_i != wr_tag_i);
        tag_o  = ent_tag_i;
      end
      RD_SRC_ARRAY: begin
        data_o = ent_data_i;
        busy_o = ent_busy_i;
        tag_o  = ent_tag_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised N-read/1-write integer register file with a per-register
// busy/tag scoreboard. Issue marks a destination pending; writeback clears it
// only when the producer tag matches; flush drops all pending producers.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned XLEN   = RF_XLEN,
  parameter int unsigned NREG   = RF_NREG,
  parameter int unsigned NUM_RD = RF_NUM_RD,
  parameter int unsigned TAG_W  = RF_TAG_W,
  localparam int unsigned AW    = $clog2(NREG)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [XLEN-1:0]         wr_data,
  input  logic [TAG_W-1:0]        wr_tag,
  input  logic                    iss_en,
  input  logic [AW-1:0]           iss_addr,
  input  logic [TAG_W-1:0]        iss_tag,
  input  logic [NUM_RD-1:0]       rd_en,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*XLEN-1:0]  rd_data,
  output logic [NUM_RD-1:0]       rd_busy,
  output logic [NUM_RD*TAG_W-1:0] rd_tag
);

  logic [XLEN-1:0]  regs_q [NREG];
  logic [XLEN-1:0]  regs_d [NREG];
  logic [NREG-1:0]  busy_q, busy_d;
  logic [TAG_W-1:0] tag_q  [NREG];
  logic [TAG_W-1:0] tag_d  [NREG];

  // Next state: write (with tag-matched busy clear), then flush or issue;
  // issue is applied last so it overrides a same-edge write to the same register.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (wr_en && (wr_addr != AW'(REG_ZERO))) begin
      regs_d[wr_addr] = wr_data;
      if (busy_q[wr_addr] && (tag_q[wr_addr] == wr_tag)) begin
        busy_d[wr_addr] = 1'b0;
      end
    end
    if (flush) begin
      busy_d = '0;
    end else if (iss_en && (iss_addr != AW'(REG_ZERO))) begin
      busy_d[iss_addr] = 1'b1;
      tag_d[iss_addr]  = iss_tag;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = rd_addr[gi*AW +: AW];

    regfile_rd_port #(
      .XLEN  (XLEN),
      .AW    (AW),
      .TAG_W (TAG_W)
    ) u_port (
      .rst_i      (rst),
      .flush_i    (flush),
      .en_i       (rd_en[gi]),
      .addr_i     (addr),
      .wr_en_i    (wr_en),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data),
      .wr_tag_i   (wr_tag),
      .ent_data_i (regs_q[addr]),
      .ent_busy_i (busy_q[addr]),
      .ent_tag_i  (tag_q[addr]),
      .data_o     (rd_data[gi*XLEN +: XLEN]),
      .busy_o     (rd_busy[gi]),
      .tag_o      (rd_tag[gi*TAG_W +: TAG_W])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Testbench for regfile_scoreboard with four read ports: directed scenarios
// plus randomized traffic against an array-based reference model.
module tb_regfile_scoreboard;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int NUM_RD = 4;
  localparam int TAG_W  = 4;
  localparam int AW     = 5;

  logic                    clk = 1'b0;
  logic                    rst, flush, wr_en, iss_en;
  logic [AW-1:0]           wr_addr, iss_addr;
  logic [XLEN-1:0]         wr_data;
  logic [TAG_W-1:0]        wr_tag, iss_tag;
  logic [NUM_RD-1:0]       rd_en;
  logic [NUM_RD*AW-1:0]    rd_addr;
  logic [NUM_RD*XLEN-1:0]  rd_data;
  logic [NUM_RD-1:0]       rd_busy;
  logic [NUM_RD*TAG_W-1:0] rd_tag;

  int n_tests = 0;
  int n_fail  = 0;

  logic [XLEN-1:0]  m_regs [NREG];
  logic             m_busy [NREG];
  logic [TAG_W-1:0] m_tag  [NREG];

  always #5 clk = ~clk;

  regfile_scoreboard #(
    .XLEN   (XLEN),
    .NREG   (NREG),
    .NUM_RD (NUM_RD),
    .TAG_W  (TAG_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_tag   (wr_tag),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .iss_tag  (iss_tag),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .rd_tag   (rd_tag)
  );

  // Expected result of read port p for the inputs currently applied.
  function automatic void model_rd(input int p, output logic [XLEN-1:0] d,
                                   output logic b, output logic [TAG_W-1:0] t);
    int a;
    a = int'(rd_addr[p*AW +: AW]);
    d = '0; b = 1'b0; t = '0;
    if (rst || flush || !rd_en[p] || a == 0) return;
    if (wr_en && int'(wr_addr) == a) begin
      d = wr_data;
      b = m_busy[a] && (m_tag[a] != wr_tag);
      t = m_tag[a];
    end else begin
      d = m_regs[a];
      b = m_busy[a];
      t = m_tag[a];
    end
  endfunction

  // Advance one clock edge and apply the same edge to the reference model.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        m_regs[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
      end
    end else begin
      if (wr_en && wr_addr != 0) begin
        m_regs[wr_addr] = wr_data;
        if (m_busy[wr_addr] && m_tag[wr_addr] == wr_tag) m_busy[wr_addr] = 1'b0;
      end
      if (flush) begin
        for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
      end else if (iss_en && iss_addr != 0) begin
        m_busy[iss_addr] = 1'b1;
        m_tag[iss_addr]  = iss_tag;
      end
    end
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0; wr_en = 1'b0; iss_en = 1'b0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, a1, a2, a3);
    rd_en   = '1;
    rd_addr = {a3, a2, a1, a0};
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h1234_5678; wr_tag = 4'd1;
    iss_en = 1'b1; iss_addr = 5'd5; iss_tag = 4'd2;
    set_rd(5'd5, 5'd6, 5'd1, 5'd31);
    #1;
    n_tests++;
    if (rd_data !== '0 || rd_busy !== '0 || rd_tag !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h busy=%b tag=%h required all zero", rd_data, rd_busy, rd_tag);
    end
    tick();
    idle();
    for (int base = 1; base < NREG; base += 4) begin
      set_rd(AW'(base), AW'(base + 1), AW'(base + 2), AW'(base + 3));
      #1;
      n_tests++;
      if (rd_data !== '0 || rd_busy !== '0) begin
        n_fail++;
        $display("FAIL reset_state base=%0d: got data=%h busy=%b required 0/0", base, rd_data, rd_busy);
      end
    end
  endtask

  task automatic test_issue_commit();
    idle();
    iss_en = 1'b1; iss_addr = 5'd5; iss_tag = 4'd3;
    tick();
    idle();
    set_rd(5'd5, 5'd0, 5'd0, 5'd0);
    #1;
    n_tests++;
    if (rd_busy[0] !== 1'b1 || rd_tag[3:0] !== 4'd3) begin
      n_fail++;
      $display("FAIL issue_busy: got busy=%b tag=%0d required busy=1 tag=3", rd_busy[0], rd_tag[3:0]);
    end
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF; wr_tag = 4'd3;
    #1;
    n_tests++;
    if (rd_data[31:0] !== 32'hDEAD_BEEF || rd_busy[0] !== 1'b0 || rd_tag[3:0] !== 4'd3) begin
      n_fail++;
      $display("FAIL commit_bypass: got data=%h busy=%b tag=%0d required deadbeef/0/3", rd_data[31:0], rd_busy[0], rd_tag[3:0]);
    end
    tick();
    idle();
    #1;
    n_tests++;
    if (rd_data[31:0] !== 32'hDEAD_BEEF || rd_busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL commit_after: got data=%h busy=%b required deadbeef/0", rd_data[31:0], rd_busy[0]);
    end
  endtask

  task automatic test_stale_tag();
    idle();
    set_rd(5'd7, 5'd7, 5'd0, 5'd0);
    iss_en = 1'b1; iss_addr = 5'd7; iss_tag = 4'd2;
    tick();
    iss_tag = 4'd9;
    tick();
    idle();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h11; wr_tag = 4'd2;
    #1;
    n_tests++;
    if (rd_data[31:0] !== 32'h11 || rd_busy[0] !== 1'b1 || rd_tag[3:0] !== 4'd9) begin
      n_fail++;
      $display("FAIL stale_bypass: got data=%h busy=%b tag=%0d required 11/1/9", rd_data[31:0], rd_busy[0], rd_tag[3:0]);
    end
    tick();
    idle();
    #1;
    n_tests++;
    if (rd_data[31:0] !== 32'h11 || rd_busy[0] !== 1'b1 || rd_tag[3:0] !== 4'd9) begin
      n_fail++;
      $display("FAIL stale_after: got data=%h busy=%b tag=%0d required 11/1/9", rd_data[31:0], rd_busy[0], rd_tag[3:0]);
    end
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h22; wr_tag = 4'd9;
    tick();
    idle();
    #1;
    n_tests++;
    if (rd_data[31:0] !== 32'h22 || rd_busy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_clear: got data=%h busy=%b required 22/0", rd_data[31:0], rd_busy[1]);
    end
  endtask

  task automatic test_same_edge();
    idle();
    set_rd(5'd4, 5'd0, 5'd0, 5'd0);
    iss_en = 1'b1; iss_addr = 5'd4; iss_tag = 4'd6;
    wr_en  = 1'b1; wr_addr  = 5'd4; wr_data = 32'hCAFE_0004; wr_tag = 4'd6;
    #1;
    n_tests++;
    if (rd_data[31:0] !== 32'hCAFE_0004 || rd_busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL same_edge_bypass: got data=%h busy=%b required cafe0004/0", rd_data[31:0], rd_busy[0]);
    end
    tick();
    idle();
    #1;
    n_tests++;
    if (rd_data[31:0] !== 32'hCAFE_0004 || rd_busy[0] !== 1'b1 || rd_tag[3:0] !== 4'd6) begin
      n_fail++;
      $display("FAIL same_edge_after: got data=%h busy=%b tag=%0d required cafe0004/1/6", rd_data[31:0], rd_busy[0], rd_tag[3:0]);
    end
  endtask

  task automatic test_flush();
    idle();
    iss_en = 1'b1;
    iss_addr = 5'd3;  iss_tag = 4'd1; tick();
    iss_addr = 5'd8;  iss_tag = 4'd2; tick();
    iss_addr = 5'd12; iss_tag = 4'd3; tick();
    idle();
    set_rd(5'd3, 5'd8, 5'd12, 5'd9);
    #1;
    n_tests++;
    if (rd_busy !== 4'b0111) begin
      n_fail++;
      $display("FAIL flush_pre_busy: got %b required 0111", rd_busy);
    end
    flush = 1'b1;
    iss_en = 1'b1; iss_addr = 5'd9; iss_tag = 4'd5;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55; wr_tag = 4'd0;
    #1;
    n_tests++;
    if (rd_data !== '0 || rd_busy !== '0 || rd_tag !== '0) begin
      n_fail++;
      $display("FAIL flush_outputs: got data=%h busy=%b tag=%h required all zero", rd_data, rd_busy, rd_tag);
    end
    tick();
    idle();
    #1;
    n_tests++;
    if (rd_busy !== 4'b0000 || rd_data[31:0] !== 32'h55 || rd_tag !== 16'h0321) begin
      n_fail++;
      $display("FAIL flush_after: got busy=%b x3=%h tags=%h required 0000/55/0321", rd_busy, rd_data[31:0], rd_tag);
    end
  endtask

  task automatic test_x0_multiport();
    idle();
    set_rd(5'd0, 5'd0, 5'd0, 5'd0);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; wr_tag = 4'd7;
    iss_en = 1'b1; iss_addr = 5'd0; iss_tag = 4'd7;
    #1;
    n_tests++;
    if (rd_data !== '0 || rd_busy !== '0 || rd_tag !== '0) begin
      n_fail++;
      $display("FAIL x0_bypass: got data=%h busy=%b tag=%h required zero", rd_data, rd_busy, rd_tag);
    end
    tick();
    idle();
    #1;
    n_tests++;
    if (rd_data !== '0 || rd_busy !== '0 || rd_tag !== '0) begin
      n_fail++;
      $display("FAIL x0_after: got data=%h busy=%b tag=%h required zero", rd_data, rd_busy, rd_tag);
    end
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hA0A0_A0A0; wr_tag = 4'd0;
    tick();
    wr_addr = 5'd11; wr_data = 32'hB1B1_B1B1;
    iss_en = 1'b1; iss_addr = 5'd11; iss_tag = 4'd4;
    tick();
    idle();
    set_rd(5'd10, 5'd10, 5'd0, 5'd11);
    #1;
    n_tests++;
    if (rd_data !== {32'hB1B1_B1B1, 32'h0, 32'hA0A0_A0A0, 32'hA0A0_A0A0} ||
        rd_busy !== 4'b1000 || rd_tag !== 16'h4000) begin
      n_fail++;
      $display("FAIL multiport: got data=%h busy=%b tag=%h required b1b1b1b1_00000000_a0a0a0a0_a0a0a0a0/1000/4000",
               rd_data, rd_busy, rd_tag);
    end
    rd_en = 4'b0101;
    #1;
    n_tests++;
    if (rd_data !== {32'h0, 32'h0, 32'h0, 32'hA0A0_A0A0} || rd_busy !== 4'b0000 || rd_tag !== 16'h0000) begin
      n_fail++;
      $display("FAIL rd_en_mask: got data=%h busy=%b tag=%h required port0 only", rd_data, rd_busy, rd_tag);
    end
  endtask

  task automatic test_random();
    logic [XLEN-1:0]  ed;
    logic             eb;
    logic [TAG_W-1:0] et;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst      = ($urandom_range(0, 39) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = AW'($urandom_range(0, 7));
      wr_data  = $urandom;
      wr_tag   = TAG_W'($urandom_range(0, 3));
      iss_en   = 1'($urandom_range(0, 1));
      iss_addr = AW'($urandom_range(0, 7));
      iss_tag  = TAG_W'($urandom_range(0, 3));
      rd_en    = NUM_RD'($urandom);
      for (int p = 0; p < NUM_RD; p++) rd_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
      #1;
      for (int p = 0; p < NUM_RD; p++) begin
        model_rd(p, ed, eb, et);
        n_tests++;
        if (rd_data[p*XLEN +: XLEN] !== ed || rd_busy[p] !== eb || rd_tag[p*TAG_W +: TAG_W] !== et) begin
          n_fail++;
          $display("FAIL random cyc=%0d port=%0d: got data=%h busy=%b tag=%0d required %h/%b/%0d",
                   cyc, p, rd_data[p*XLEN +: XLEN], rd_busy[p], rd_tag[p*TAG_W +: TAG_W], ed, eb, et);
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
    end
    test_reset();
    test_issue_commit();
    test_stale_tag();
    test_same_edge();
    test_flush();
    test_x0_multiport();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
